// File: rtl/sel_mux_pipe.sv
// sel_mux_pipe
// Pipelined N-to-1 selector. The selected word is registered together with its
// select value and handed downstream over a valid/ready handshake. A two-entry
// skid store (main register M plus skid register S) lets in_ready be a pure
// register, so it never depends combinationally on out_ready.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   upstream word valid
//   in_ready   block can accept (registered, high while skid entry is empty)
//   in_sel     channel to select
//   in_data    packed channels, channel k at [k*WIDTH +: WIDTH]
//   out_valid  out_data/out_ch valid
//   out_ready  downstream accepts
//   out_data   selected word (registered)
//   out_ch     in_sel that produced out_data
//   err        sticky out-of-range select flag
//   err_clr    synchronous clear of err (a coincident new error wins)
module sel_mux_pipe #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SEL_W-1:0]          in_sel,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_ch,
  output logic                      err,
  input  logic                      err_clr
);

  // State encodes {M valid, S valid}.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b10,
    ST_FULL  = 2'b11
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_in_ready;
  logic               r_err;
  logic [WIDTH-1:0]   r_m_data_p1;
  logic [SEL_W-1:0]   r_m_ch_p1;
  logic [WIDTH-1:0]   r_s_data_p1;
  logic [SEL_W-1:0]   r_s_ch_p1;

  logic               w_in_xfer;
  logic               w_out_xfer;
  logic               w_oor_p0;
  logic [WIDTH-1:0]   w_sel_word_p0;
  logic               w_m_load_in;
  logic               w_m_load_s;
  logic               w_s_load;

  // Out-of-range selects produce an all-zero word; only in-range channels are
  // ever indexed, so the part-select never runs past the packed input.
  function automatic logic [WIDTH-1:0] sel_word(
    input logic [CHANNELS*WIDTH-1:0] data,
    input logic [SEL_W-1:0]          sel
  );
    logic [WIDTH-1:0] w;
    w = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (int'(sel) == k) w = data[k*WIDTH +: WIDTH];
    end
    return w;
  endfunction

  function automatic logic sel_out_of_range(input logic [SEL_W-1:0] sel);
    return int'(sel) >= CHANNELS;
  endfunction

  // ---- stage p0: select and handshake decode ----
  assign w_in_xfer     = in_valid && r_in_ready;
  assign w_out_xfer    = out_valid && out_ready;
  assign w_sel_word_p0 = sel_word(in_data, in_sel);
  assign w_oor_p0      = sel_out_of_range(in_sel);

  always_comb begin
    w_state_nxt = r_state;
    w_m_load_in = 1'b0;
    w_m_load_s  = 1'b0;
    w_s_load    = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_in_xfer) begin
          w_state_nxt = ST_ONE;
          w_m_load_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (w_in_xfer && w_out_xfer) begin
          w_m_load_in = 1'b1;
        end else if (w_in_xfer) begin
          w_state_nxt = ST_FULL;
          w_s_load    = 1'b1;
        end else if (w_out_xfer) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so only the drain path can fire.
        if (w_out_xfer) begin
          w_state_nxt = ST_ONE;
          w_m_load_s  = 1'b1;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  // ---- stage p1: registered control ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b1;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != ST_FULL);
      if (w_in_xfer && w_oor_p0) begin
        r_err <= 1'b1;
      end else if (err_clr) begin
        r_err <= 1'b0;
      end
    end
  end

  // M drives the outputs directly, so it is cleared on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m_data_p1 <= '0;
      r_m_ch_p1   <= '0;
    end else if (w_m_load_in) begin
      r_m_data_p1 <= w_sel_word_p0;
      r_m_ch_p1   <= in_sel;
    end else if (w_m_load_s) begin
      r_m_data_p1 <= r_s_data_p1;
      r_m_ch_p1   <= r_s_ch_p1;
    end
  end

  // S contents are only observed while S is valid.
  always_ff @(posedge clk) begin
    if (w_s_load) begin
      r_s_data_p1 <= w_sel_word_p0;
      r_s_ch_p1   <= in_sel;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_state[1];
  assign out_data  = r_m_data_p1;
  assign out_ch    = r_m_ch_p1;
  assign err       = r_err;

endmodule

// File: doc/sel_mux_pipe.md
# sel_mux_pipe

Parametrised, pipelined N-to-1 selector with valid/ready handshake on both sides and a two-entry skid buffer. It generalises the datapath's fixed 2:1 operand/destination muxes to CHANNELS inputs of WIDTH bits. It registers the selected word so the selection can sit on a stage boundary, for example between ID and EX or ahead of the write-back port, without adding combinational depth. It also flags out-of-range selects.

## Interface
- WIDTH, 32: data width per channel.
- CHANNELS, 4: number of input channels; legal range 2..16.
- SEL_W, 2: select width; must satisfy 2**SEL_W >= CHANNELS.

Ports:
- clk  in  1  rising-edge clock; the block uses this single clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream word valid.
- in_ready  out  1  block can accept; registered, equals "skid entry empty".
- in_sel  in  SEL_W  channel to select.
- in_data  in  CHANNELS*WIDTH  packed channels; channel k occupies bits [k*WIDTH +: WIDTH].
- out_valid  out  1  out_data/out_ch valid.
- out_ready  in  1  downstream accepts.
- out_data  out  WIDTH  selected word, registered.
- out_ch  out  SEL_W  in_sel that produced out_data.
- err  out  1  sticky out-of-range select flag.
- err_clr  in  1  synchronous clear of err.

## Operation
- Input transfer: in_valid && in_ready at a rising edge. Output transfer: out_valid && out_ready at a rising edge.
- Selection happens at input transfer. The captured word is in_data[in_sel*WIDTH +: WIDTH] together with in_sel.
- Out-of-range select (in_sel >= CHANNELS):
  - The captured word is all zeros and in_sel is carried unchanged.
  - err is set on the following edge.
  - The transfer still completes normally.
- Storage is a main register (M, drives the outputs) and a skid register (S).
- Capacity is 2 words, and the block is full when both M and S are valid. The state is {M valid, S valid}: EMPTY(0,0), ONE(1,0), FULL(1,1).
- EMPTY:
  - Input transfer -> ONE, word loaded into M.
- ONE:
  - Input transfer with output transfer -> ONE, new word into M.
  - Input transfer without output transfer -> FULL, new word into S.
  - Output transfer only -> EMPTY.
- FULL:
  - in_ready=0, so no input transfer is possible.
  - Output transfer -> ONE, S moves into M.
- Ordering is strictly FIFO, with no reordering or dropping.
- in_ready is a register: in_ready = !S_valid. It never depends combinationally on out_ready.
- err_clr:
  - err_clr clears err on the next edge.
  - If err_clr and a new out-of-range capture coincide, err ends up set (set wins).
- out_data and out_ch hold their last value while out_valid=0.
- With out_valid=1 and out_ready=0, out_data and out_ch stay stable.

## Timing
- Reset (async assert, takes effect immediately):
  - out_valid=0, out_data=0, out_ch=0, err=0, in_ready=1.
  - M and S are both invalid.
- Any words in flight when reset asserts are discarded; there is no partial output after deassert.
- Latency: input transfer at edge n -> out_valid=1 after edge n when the block was EMPTY, or when it was ONE and an output transfer also occurred at edge n.
- Throughput: 1 word/cycle sustained while out_ready=1.
- Backpressure: after out_ready falls, the block absorbs at most one further word (into S), then in_ready=0 from the next cycle.
- Recovery: the first output transfer from FULL raises in_ready on the following cycle.
- err timing: err rises one cycle after the offending input transfer.

## Test plan
- Reset and basic select, WIDTH=32, CHANNELS=4:
  - Apply reset, then a single word with in_sel=2 and channel 2 = 0xDEADBEEF.
  - Required: out_valid=1 one cycle later, out_data=0xDEADBEEF, out_ch=2, err=0.
- Streaming:
  - 8 words with sel cycling 0..3, out_ready=1 held.
  - Required: one output per cycle, in order, data matching the selected channel each cycle, in_ready=1 throughout.
- Backpressure:
  - Drop out_ready with 1 word held, then offer 3 more.
  - Required: exactly one more word is accepted, and in_ready=0 from the next cycle.
  - Raise out_ready. Required: both words drain in order and in_ready returns to 1.
- Out of range, CHANNELS=3, SEL_W=2:
  - in_sel=3.
  - Required: out_data=0, out_ch=3, err=1 on the following cycle.
  - err_clr pulse. Required: err=0.
  - err_clr asserted together with another in_sel=3 word. Required: err stays 1.
- Reset mid-operation:
  - Assert rst while the block is FULL.
  - Required: out_valid, out_data and out_ch drop to 0 immediately, in_ready=1, and no stale word emerges after deassert.
